// File: rtl/imem_load_arb.sv
// Arbitrates the instruction memory between the CPU fetch path and a byte-serial
// program loader; stalls the CPU during a load and restarts it at PC 0 afterwards.
//
// state   | meaning
// --------+--------------------------------------------------
// RUN     | CPU owns the memory read port
// COLLECT | CPU stalled, assembling a 32-bit word from bytes
// WRITE   | CPU stalled, one-cycle write of the assembled word
module imem_load_arb #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   cpu_pc,
    output logic [31:0]   cpu_inst,
    output logic          cpu_stall,
    output logic          cpu_restart,
    input  logic          ld_start,
    input  logic [AW:0]   ld_count,
    input  logic          ld_abort,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    output logic          ld_ready,
    output logic          ld_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t      state, state_nx;
    logic [AW:0] ptr, cnt, ptr_inc;
    logic [1:0]  bcnt;
    logic [31:0] shift;
    logic        restart_q, err_q;

    logic        load_go, byte_take, word_done, pulse_restart, pulse_err;
    logic        unused_pc;

    assign unused_pc   = ^{cpu_pc[31:AW+2], cpu_pc[1:0]};
    assign ptr_inc     = ptr + 1'b1;
    assign mem_wdata   = shift;
    assign cpu_restart = restart_q;
    assign ld_err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        load_go       = 1'b0;
        byte_take     = 1'b0;
        word_done     = 1'b0;
        pulse_restart = 1'b0;
        pulse_err     = 1'b0;
        cpu_inst      = 32'h0;
        cpu_stall     = 1'b1;
        ld_ready      = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = ptr[AW-1:0];

        case (state)
            RUN: begin
                cpu_stall = 1'b0;
                cpu_inst  = mem_rdata;
                mem_addr  = cpu_pc[AW+1:2];
                if (ld_start && (ld_count != '0)) begin
                    load_go  = 1'b1;
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                ld_ready = 1'b1;
                if (ld_abort) begin
                    state_nx      = RUN;
                    pulse_err     = 1'b1;
                    pulse_restart = 1'b1;
                end else if (ld_valid) begin
                    byte_take = 1'b1;
                    if (bcnt == 2'd3) begin
                        state_nx = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                word_done = 1'b1;
                // an abort here still lets this word land in memory
                if (ld_abort) begin
                    state_nx      = RUN;
                    pulse_err     = 1'b1;
                    pulse_restart = 1'b1;
                end else if (ptr_inc == cnt) begin
                    state_nx      = RUN;
                    pulse_restart = 1'b1;
                end else begin
                    state_nx = COLLECT;
                end
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            bcnt      <= 2'd0;
            shift     <= 32'h0;
            restart_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            restart_q <= pulse_restart;
            err_q     <= pulse_err;
            if (load_go) begin
                cnt  <= (ld_count > DEPTH) ? DEPTH : ld_count;
                ptr  <= '0;
                bcnt <= 2'd0;
            end
            if (byte_take) begin
                shift <= {shift[23:0], ld_byte};
                bcnt  <= bcnt + 2'd1;
            end
            if (word_done) begin
                ptr  <= ptr_inc;
                bcnt <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_imem_load_arb.sv
// Directed bench for imem_load_arb: a behavioural memory sits on the mem_* port and
// each load is driven cycle by cycle while writes, stall and pulses are logged.
module tb_imem_load_arb;
    localparam int AW = 6;

    logic          clk, rst;
    logic [31:0]   cpu_pc, cpu_inst;
    logic          cpu_stall, cpu_restart;
    logic          ld_start, ld_abort, ld_valid, ld_ready, ld_err;
    logic [AW:0]   ld_count;
    logic [7:0]    ld_byte;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    logic        pl_we;
    logic [7:0]  prog [0:511];

    int nvec = 0;
    int nerr = 0;
    int wr_cyc[$], wr_addr[$], rs_cyc[$], er_cyc[$];
    logic [31:0] wr_data[$];
    int stall_n;

    imem_load_arb #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
        .cpu_stall(cpu_stall), .cpu_restart(cpu_restart),
        .ld_start(ld_start), .ld_count(ld_count), .ld_abort(ld_abort),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready), .ld_err(ld_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (pl_we) mem[1] <= 32'h20050021;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input int count, input int nbytes, input int gap_at,
                            input int gap_len, input int abort_at, input int maxcyc);
        int consumed, gap_used;
        bit aborted, acc;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        rs_cyc.delete(); er_cyc.delete();
        stall_n = 0; consumed = 0; gap_used = 0; aborted = 0;
        ld_start = 1'b1;
        ld_count = (AW+1)'(count);
        tick();
        ld_start = 1'b0;
        for (int cyc = 1; cyc <= maxcyc; cyc++) begin
            ld_abort = 1'b0;
            if (abort_at >= 0 && !aborted && consumed == abort_at) begin
                ld_abort = 1'b1;
                aborted  = 1;
            end
            if (consumed == gap_at && gap_used < gap_len) begin
                ld_valid = 1'b0;
                gap_used++;
            end else begin
                ld_valid = (consumed < nbytes);
            end
            ld_byte = prog[consumed];
            #1;
            if (mem_we) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(mem_wdata);
            end
            if (cpu_stall) stall_n++;
            if (cpu_restart) rs_cyc.push_back(cyc);
            if (ld_err) er_cyc.push_back(cyc);
            acc = ld_valid && ld_ready;
            tick();
            if (acc) consumed++;
        end
        ld_valid = 1'b0;
        ld_abort = 1'b0;
    endtask

    initial begin
        int consumed;
        bit acc;
        rst = 1'b1; pl_we = 1'b1; cpu_pc = 32'h4;
        ld_start = 0; ld_count = '0; ld_abort = 0; ld_valid = 0; ld_byte = 8'h0;
        for (int i = 0; i < 512; i++) prog[i] = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        pl_we = 1'b0;
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_ready", 32'(ld_ready), 0);
        chk("rst_we", 32'(mem_we), 0);
        rst = 1'b0;
        #1;
        chk("run_inst", cpu_inst, 32'h20050021);
        chk("run_addr", 32'(mem_addr), 1);
        chk("run_stall", 32'(cpu_stall), 0);
        chk("run_restart", 32'(cpu_restart), 0);
        chk("run_err", 32'(ld_err), 0);
        tick();

        // two-word load, back-to-back bytes
        {prog[0], prog[1], prog[2], prog[3]} = 32'h3C03C000;
        {prog[4], prog[5], prog[6], prog[7]} = 32'h20050021;
        run_load(2, 8, -1, 0, -1, 13);
        chk("l2_nwr", wr_cyc.size(), 2);
        if (wr_cyc.size() == 2) begin
            chk("l2_c0", wr_cyc[0], 5);
            chk("l2_a0", wr_addr[0], 0);
            chk("l2_d0", wr_data[0], 32'h3C03C000);
            chk("l2_c1", wr_cyc[1], 10);
            chk("l2_a1", wr_addr[1], 1);
            chk("l2_d1", wr_data[1], 32'h20050021);
        end
        chk("l2_stall", stall_n, 10);
        chk("l2_nrs", rs_cyc.size(), 1);
        if (rs_cyc.size() == 1) chk("l2_rs", rs_cyc[0], 11);
        chk("l2_nerr", er_cyc.size(), 0);
        cpu_pc = 32'h0;
        #1;
        chk("l2_fetch0", cpu_inst, 32'h3C03C000);

        // same load with a 3-cycle gap after the second byte
        run_load(2, 8, 2, 3, -1, 16);
        chk("gap_nwr", wr_cyc.size(), 2);
        if (wr_cyc.size() == 2) begin
            chk("gap_c0", wr_cyc[0], 8);
            chk("gap_d0", wr_data[0], 32'h3C03C000);
            chk("gap_c1", wr_cyc[1], 13);
            chk("gap_d1", wr_data[1], 32'h20050021);
        end
        chk("gap_stall", stall_n, 13);
        chk("gap_nrs", rs_cyc.size(), 1);
        if (rs_cyc.size() == 1) chk("gap_rs", rs_cyc[0], 14);

        // zero-count request is ignored
        ld_start = 1'b1; ld_count = '0;
        tick();
        ld_start = 1'b0;
        #1;
        chk("zero_stall", 32'(cpu_stall), 0);
        chk("zero_ready", 32'(ld_ready), 0);
        tick();
        chk("zero_stall2", 32'(cpu_stall), 0);

        // oversize count clamps to 64 words
        for (int i = 0; i < 256; i++) prog[i] = 8'(i);
        run_load(100, 256, -1, 0, -1, 323);
        chk("big_nwr", wr_cyc.size(), 64);
        for (int i = 0; i < wr_addr.size(); i++) chk("big_addr", wr_addr[i], i);
        if (wr_cyc.size() == 64) begin
            chk("big_d0", wr_data[0], 32'h00010203);
            chk("big_d63", wr_data[63], 32'hFCFDFEFF);
            chk("big_c63", wr_cyc[63], 320);
        end
        chk("big_stall", stall_n, 320);
        chk("big_nrs", rs_cyc.size(), 1);
        if (rs_cyc.size() == 1) chk("big_rs", rs_cyc[0], 321);

        // abort after six bytes of a three-word load
        for (int i = 0; i < 12; i++) prog[i] = 8'hA0 + 8'(i);
        run_load(3, 12, -1, 0, 6, 12);
        chk("ab_nwr", wr_cyc.size(), 1);
        if (wr_cyc.size() == 1) begin
            chk("ab_a0", wr_addr[0], 0);
            chk("ab_d0", wr_data[0], 32'hA0A1A2A3);
        end
        chk("ab_stall", stall_n, 8);
        chk("ab_nerr", er_cyc.size(), 1);
        if (er_cyc.size() == 1) chk("ab_err", er_cyc[0], 9);
        chk("ab_nrs", rs_cyc.size(), 1);
        if (rs_cyc.size() == 1) chk("ab_rs", rs_cyc[0], 9);
        run_load(1, 4, -1, 0, -1, 8);
        chk("ab2_nwr", wr_cyc.size(), 1);
        if (wr_cyc.size() == 1) chk("ab2_c0", wr_cyc[0], 5);
        chk("ab2_nrs", rs_cyc.size(), 1);
        if (rs_cyc.size() == 1) chk("ab2_rs", rs_cyc[0], 6);

        // async reset mid-load after byte 2 of word 1
        for (int i = 0; i < 8; i++) prog[i] = 8'h10 + 8'(i);
        ld_start = 1'b1; ld_count = 7'd2;
        tick();
        ld_start = 1'b0;
        consumed = 0;
        for (int c = 0; c < 20 && consumed < 6; c++) begin
            ld_valid = 1'b1;
            ld_byte  = prog[consumed];
            #1;
            acc = ld_ready;
            tick();
            if (acc) consumed++;
        end
        ld_valid = 1'b0;
        chk("rs_consumed", consumed, 6);
        #1 rst = 1'b1;
        #1;
        chk("rs_stall", 32'(cpu_stall), 0);
        chk("rs_ready", 32'(ld_ready), 0);
        chk("rs_restart", 32'(cpu_restart), 0);
        rst = 1'b0;
        tick();
        chk("rs_restart2", 32'(cpu_restart), 0);
        chk("rs_err2", 32'(ld_err), 0);
        cpu_pc = 32'h0;
        #1;
        chk("rs_kept", cpu_inst, 32'h10111213);
        run_load(1, 4, -1, 0, -1, 8);
        chk("rs_nwr", wr_cyc.size(), 1);
        if (wr_cyc.size() == 1) begin
            chk("rs_a0", wr_addr[0], 0);
            chk("rs_c0", wr_cyc[0], 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
